// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state encoding and timing derivations for the LED frame sequencer.
package led_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } seq_state_t;

    function automatic int tx_cycles(input int bits_per_pixel, input int cycles_per_bit);
        return bits_per_pixel * cycles_per_bit;
    endfunction

    // Shortest legal frame: every pixel slot plus at least one GAP cycle for frame_done.
    function automatic int min_period(input int num_pixels, input int bits_per_pixel,
                                      input int cycles_per_bit);
        return num_pixels * (tx_cycles(bits_per_pixel, cycles_per_bit) + 2) + 1;
    endfunction

endpackage

// File: rtl/led_mod_counter.sv
// led_mod_counter: modulo-N counter with enable, synchronous clear and wrap pulse.
module led_mod_counter #(
    parameter int MODULUS = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic wrap_o
);

    localparam int W = MODULUS > 1 ? $clog2(MODULUS) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         last;

    assign last   = cnt_q == W'(MODULUS - 1);
    assign wrap_o = en_i && last;

    always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : last ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: per-pixel READ/LOAD/SHIFT timing for addressable-LED chains,
// padded to a fixed frame period with a decimated newframe pulse.
module led_frame_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_PIXELS        = 64,
    parameter int BITS_PER_PIXEL    = 24,
    parameter int CYCLES_PER_BIT    = 15,
    parameter int FRAME_PERIOD      = 375000,
    parameter int FRAMES_PER_UPDATE = 50
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_i,
    input  logic                          oneshot_i,
    input  logic                          trigger_i,
    input  logic                          reverse_i,
    output logic [$clog2(NUM_PIXELS)-1:0] pixel_o,
    output logic                          load_sreg_o,
    output logic                          transmit_pixel_o,
    output logic                          busy_o,
    output logic                          frame_done_o,
    output logic                          newframe_o
);

    localparam int TX = tx_cycles(BITS_PER_PIXEL, CYCLES_PER_BIT);
    localparam int PW = $clog2(NUM_PIXELS);

    if (NUM_PIXELS < 2) begin : g_pix_chk
        $error("NUM_PIXELS must be at least 2");
    end
    if (FRAMES_PER_UPDATE < 1) begin : g_upd_chk
        $error("FRAMES_PER_UPDATE must be at least 1");
    end
    if (FRAME_PERIOD < min_period(NUM_PIXELS, BITS_PER_PIXEL, CYCLES_PER_BIT)) begin : g_period_chk
        $error("FRAME_PERIOD too short for the pixel sweep");
    end

    seq_state_t    state_q, state_d;
    logic [PW-1:0] pixel_q, pixel_d;
    logic          rev_q, rev_d;
    logic [PW-1:0] first_pix;
    logic          start, pix_last, bit_wrap, period_wrap, frame_end;

    assign busy_o           = state_q != S_IDLE;
    assign load_sreg_o      = state_q == S_LOAD;
    assign transmit_pixel_o = state_q == S_SHIFT;
    assign pixel_o          = pixel_q;
    assign frame_end        = state_q == S_GAP && period_wrap;
    assign frame_done_o     = frame_end;

    assign start     = state_q == S_IDLE && enable_i && (!oneshot_i || trigger_i);
    assign first_pix = reverse_i ? '0 : PW'(NUM_PIXELS - 1);
    assign pix_last  = pixel_q == (rev_q ? PW'(NUM_PIXELS - 1) : '0);

    led_mod_counter #(.MODULUS(TX)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (transmit_pixel_o),
        .clr_i (!transmit_pixel_o),
        .wrap_o(bit_wrap)
    );

    // Runs through every non-IDLE cycle; wraps on its own at each free-run frame boundary.
    led_mod_counter #(.MODULUS(FRAME_PERIOD)) u_period_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (busy_o),
        .clr_i (start),
        .wrap_o(period_wrap)
    );

    led_mod_counter #(.MODULUS(FRAMES_PER_UPDATE)) u_dec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (frame_end),
        .clr_i (1'b0),
        .wrap_o(newframe_o)
    );

    always_comb begin
        state_d = state_q;
        pixel_d = pixel_q;
        rev_d   = rev_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_READ;
                rev_d   = reverse_i;
                pixel_d = first_pix;
            end
            S_READ:  state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (bit_wrap) begin
                if (pix_last) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_READ;
                    pixel_d = rev_q ? pixel_q + 1'b1 : pixel_q - 1'b1;
                end
            end
            S_GAP: if (frame_end) begin
                if (enable_i && !oneshot_i) begin
                    state_d = S_READ;
                    rev_d   = reverse_i;
                    pixel_d = first_pix;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pixel_q <= '0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pixel_q <= pixel_d;
            rev_q   <= rev_d;
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb_led_frame_sequencer: frame-offset reference model plus directed scenarios with literal checks.
module tb_led_frame_sequencer;

    localparam int N     = 4;
    localparam int BPP   = 2;
    localparam int CPB   = 3;
    localparam int FP    = 40;
    localparam int FPU   = 3;
    localparam int SLOT  = BPP * CPB + 2;
    localparam int SWEEP = N * SLOT;
    localparam int LIM   = 400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0, oneshot = 1'b0, trigger = 1'b0, reverse = 1'b0;
    logic [1:0] pixel;
    logic       load_sreg, transmit_pixel, busy, frame_done, newframe;

    always #5 clk = ~clk;

    led_frame_sequencer #(
        .NUM_PIXELS(N), .BITS_PER_PIXEL(BPP), .CYCLES_PER_BIT(CPB),
        .FRAME_PERIOD(FP), .FRAMES_PER_UPDATE(FPU)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .oneshot_i(oneshot),
        .trigger_i(trigger), .reverse_i(reverse), .pixel_o(pixel),
        .load_sreg_o(load_sreg), .transmit_pixel_o(transmit_pixel), .busy_o(busy),
        .frame_done_o(frame_done), .newframe_o(newframe)
    );

    int total = 0, bad = 0, cyc = 0;
    int fd_q[$], nf_q[$];

    // Model state: whether a frame is running, the cycle offset within it, its direction.
    bit m_act, m_rev;
    int m_k, m_hold, m_frames;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic m_reset();
        m_act = 0; m_rev = 0; m_k = 0; m_hold = 0; m_frames = 0;
    endtask

    function automatic int m_pix();
        if (!m_act) return m_hold;
        if (m_k < SWEEP) return m_rev ? m_k / SLOT : N - 1 - m_k / SLOT;
        return m_rev ? N - 1 : 0;
    endfunction

    task automatic m_step();
        if (!rst_n) begin
            m_reset();
        end else if (!m_act) begin
            if (enable && (!oneshot || trigger)) begin
                m_act = 1; m_k = 0; m_rev = reverse;
            end
        end else begin
            m_hold = m_pix();
            if (m_k == FP - 1) begin
                m_frames++;
                if (enable && !oneshot) begin
                    m_k = 0; m_rev = reverse;
                end else begin
                    m_act = 0;
                end
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic m_check();
        bit fd;
        if (!rst_n) m_reset();
        cyc++;
        fd = m_act && m_k == FP - 1;
        chk("pixel", int'(pixel), m_pix());
        chk("load_sreg", int'(load_sreg), int'(m_act && m_k < SWEEP && m_k % SLOT == 1));
        chk("transmit_pixel", int'(transmit_pixel), int'(m_act && m_k < SWEEP && m_k % SLOT >= 2));
        chk("busy", int'(busy), int'(m_act));
        chk("frame_done", int'(frame_done), int'(fd));
        chk("newframe", int'(newframe), int'(fd && m_frames % FPU == FPU - 1));
        if (frame_done) fd_q.push_back(cyc);
        if (newframe) nf_q.push_back(cyc);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            m_step();
            @(negedge clk);
            m_check();
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_busy(input logic v, input string nm);
        int n = 0;
        while (busy !== v && n < LIM) begin tick(1); n++; end
        chk(nm, int'(busy === v), 1);
    endtask

    task automatic wait_fd(input int target, input string nm);
        int n = 0;
        while (fd_q.size() < target && n < LIM) begin tick(1); n++; end
        chk(nm, fd_q.size(), target);
    endtask

    task automatic wait_pix(input int v, input string nm);
        int n = 0;
        while (!(busy === 1'b1 && int'(pixel) == v) && n < LIM) begin tick(1); n++; end
        chk(nm, int'(pixel), v);
    endtask

    task automatic wait_tx(input string nm);
        int n = 0;
        while (transmit_pixel !== 1'b1 && n < LIM) begin tick(1); n++; end
        chk(nm, int'(transmit_pixel), 1);
    endtask

    initial begin
        int p[41], l[41], t[41], f[41];
        int s, fdb, nfb;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("idle_busy", int'(busy), 0);
        chk("idle_pixel", int'(pixel), 0);

        // First free-run frame, pinned with literal values.
        enable = 1'b1;
        for (int i = 0; i < 41; i++) begin
            tick(1);
            p[i] = pixel; l[i] = load_sreg; t[i] = transmit_pixel; f[i] = frame_done;
        end
        chk("f1_pix0", p[0], 3);
        chk("f1_load0", l[0], 0);
        chk("f1_load1", l[1], 1);
        chk("f1_tx1", t[1], 0);
        chk("f1_tx2", t[2], 1);
        chk("f1_tx7", t[7], 1);
        chk("f1_pix8", p[8], 2);
        chk("f1_tx8", t[8], 0);
        chk("f1_load9", l[9], 1);
        chk("f1_pix31", p[31], 0);
        chk("f1_tx31", t[31], 1);
        chk("f1_tx32", t[32], 0);
        chk("f1_pix39", p[39], 0);
        chk("f1_fd38", f[38], 0);
        chk("f1_fd39", f[39], 1);
        chk("f2_pix0", p[40], 3);
        chk("f2_fd0", f[40], 0);

        // Decimation over six frames.
        wait_fd(6, "wait_six_frames");
        chk("nf_count6", nf_q.size(), 2);
        if (fd_q.size() >= 6 && nf_q.size() >= 2) begin
            chk("nf_at_fd3", nf_q[0], fd_q[2]);
            chk("nf_at_fd6", nf_q[1], fd_q[5]);
            chk("period_f1", fd_q[1] - fd_q[0], FP);
            chk("period_f5", fd_q[5] - fd_q[4], FP);
        end

        // One-shot, reversed scan; a mid-frame trigger must not queue.
        oneshot = 1'b1;
        reverse = 1'b1;
        tick(1);
        chk("os_idle", int'(busy), 0);
        tick(3);
        chk("os_no_trig", int'(busy), 0);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        chk("os_busy", int'(busy), 1);
        chk("os_pix0", int'(pixel), 0);
        tick(12);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        wait_busy(1'b0, "os_end");
        chk("os_frames", fd_q.size(), 7);
        tick(5);
        chk("os_stay_idle", int'(busy), 0);
        chk("os_no_extra", fd_q.size(), 7);

        // Free-run with enable dropped during pixel 2.
        oneshot = 1'b0;
        reverse = 1'b0;
        tick(1);
        chk("drop_busy", int'(busy), 1);
        chk("drop_pix0", int'(pixel), 3);
        s = cyc;
        wait_pix(2, "drop_reach_pix2");
        enable = 1'b0;
        wait_busy(1'b0, "drop_end");
        chk("drop_frames", fd_q.size(), 8);
        if (fd_q.size() > 0) chk("drop_fd_offset", fd_q[$] - s, FP - 1);
        tick(3);
        chk("drop_idle", int'(busy), 0);

        // Asynchronous reset in the middle of SHIFT.
        enable = 1'b1;
        tick(1);
        wait_tx("rst_reach_shift");
        rst_n = 1'b0;
        #1;
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_load", int'(load_sreg), 0);
        chk("rst_tx", int'(transmit_pixel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_nf", int'(newframe), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rel_busy", int'(busy), 1);
        chk("rel_pix0", int'(pixel), 3);
        fdb = fd_q.size();
        nfb = nf_q.size();
        wait_fd(fdb + 3, "rel_three_frames");
        chk("rel_nf_count", nf_q.size() - nfb, 1);
        if (nf_q.size() > 0 && fd_q.size() > 0) chk("rel_nf_at_fd3", nf_q[$], fd_q[$]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
